// File: rtl/lab4_pkg.sv
// lab4_pkg: shared debouncer state encoding and default timing parameters
package lab4_pkg;
    typedef enum logic [1:0] {DB_STABLE_LO, DB_CHECK_HI, DB_STABLE_HI, DB_CHECK_LO} debounce_state_t;
    localparam int DB_STABLE_CYCLES = 4;
    localparam int DB_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: generic N-flop synchroniser for asynchronous single-bit levels
module sync_chain #(
    parameter int STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk or posedge reset)
        if (reset) r <= {STAGES{RESET_LEVEL}};
        else r <= {r[STAGES-2:0], d};
    assign q = r[STAGES-1];
endmodule

// File: rtl/data_debouncer.sv
// data_debouncer: synchronise, glitch-filter and edge-detect a raw input level
module data_debouncer import lab4_pkg::*; #(
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int SYNC_STAGES = DB_SYNC_STAGES,
    parameter logic RESET_LEVEL = 1'b0,
    parameter int GLITCH_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_in,
    input  logic                glitch_clr,
    output logic                data_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    debounce_state_t state;
    logic [CW-1:0] cnt;
    logic s, abort;
    sync_chain #(.STAGES(SYNC_STAGES), .RESET_LEVEL(RESET_LEVEL)) u_sync (
        .clk(clk), .reset(reset), .d(data_in), .q(s)
    );
    assign busy = state == DB_CHECK_HI || state == DB_CHECK_LO;
    // data_out always equals the level of the current stable/check pair, so a match means the candidate died
    always_comb abort = busy && s == data_out;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= RESET_LEVEL ? DB_STABLE_HI : DB_STABLE_LO;
            data_out <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            cnt <= '0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (abort) begin
                state <= data_out ? DB_STABLE_HI : DB_STABLE_LO;
                cnt <= '0;
            end else if (s != data_out && (!busy && STABLE_CYCLES == 1 || busy && cnt == CW'(STABLE_CYCLES - 1))) begin
                state <= data_out ? DB_STABLE_LO : DB_STABLE_HI;
                data_out <= !data_out;
                rise_pulse <= !data_out;
                fall_pulse <= data_out;
                cnt <= '0;
            end else if (s != data_out) begin
                state <= data_out ? DB_CHECK_LO : DB_CHECK_HI;
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) glitch_cnt <= '0;
        else glitch_cnt <= glitch_clr ? '0 : (abort && glitch_cnt != '1) ? glitch_cnt + 1'b1 : glitch_cnt;
endmodule

// File: tb/tb_data_debouncer.sv
// tb_data_debouncer: randomized and directed check of two debouncer configurations against a run-length model
module tb_data_debouncer;
    logic clk = 1'b0, reset = 1'b1, data_in = 1'b0, glitch_clr = 1'b0;
    logic out0, rise0, fall0, busy0, out1, rise1, fall1, busy1;
    logic [7:0] gl0, gl1;
    int passed = 0, total = 0;
    int nreq [2] = '{4, 1};
    logic m_out [2], m_rise [2], m_fall [2];
    int run [2], m_gl [2];
    logic h0 [$], h1 [$];

    always #5 clk = ~clk;

    data_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0), .GLITCH_W(8)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .glitch_clr(glitch_clr),
        .data_out(out0), .rise_pulse(rise0), .fall_pulse(fall0), .busy(busy0), .glitch_cnt(gl0)
    );
    data_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b0), .GLITCH_W(8)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .glitch_clr(glitch_clr),
        .data_out(out1), .rise_pulse(rise1), .fall_pulse(fall1), .busy(busy1), .glitch_cnt(gl1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; run[i] = 0; m_gl[i] = 0;
        end
        h0 = '{1'b0, 1'b0};
        h1 = '{1'b0, 1'b0};
    endtask

    // the level seen by the filter at an edge is data_in from two edges earlier
    task automatic m_step(input int i, input logic d, input logic c);
        logic s;
        if (i == 0) begin s = h0.pop_front(); h0.push_back(d); end
        else begin s = h1.pop_front(); h1.push_back(d); end
        m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        if (s != m_out[i]) begin
            run[i]++;
            if (run[i] == nreq[i]) begin
                m_out[i] = s; m_rise[i] = s; m_fall[i] = !s; run[i] = 0;
            end
        end else begin
            if (run[i] > 0 && m_gl[i] < 255) m_gl[i]++;
            run[i] = 0;
        end
        if (c) m_gl[i] = 0;
    endtask

    task automatic compare_all();
        chk("out0", out0, m_out[0]);
        chk("rise0", rise0, m_rise[0]);
        chk("fall0", fall0, m_fall[0]);
        chk("busy0", busy0, run[0] > 0);
        chk("glitch0", gl0, m_gl[0]);
        chk("out1", out1, m_out[1]);
        chk("rise1", rise1, m_rise[1]);
        chk("fall1", fall1, m_fall[1]);
        chk("busy1", busy1, run[1] > 0);
        chk("glitch1", gl1, m_gl[1]);
    endtask

    task automatic tick(input logic d, input logic c);
        data_in = d; glitch_clr = c;
        m_step(0, d, c);
        m_step(1, d, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; m_reset();
        #1 compare_all();
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        chk("t1_out", out0, 0);
        chk("t1_glitch", gl0, 0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("t6_rise_edge2", {out1, rise1}, 2'b11);
        tick(1'b0, 1'b0);
        chk("t6_fall_next", {out1, fall1}, 2'b01);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        chk("t6_glitch0", gl0, 1);
        chk("t6_out0", out0, 0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        chk("t3_glitch", gl0, 2);
        chk("t3_out", out0, 0);
        chk("t3_busy", busy0, 0);
        for (int i = 1; i <= 7; i++) begin
            tick(1'b1, 1'b0);
            if (i == 2) chk("t2_busy_pre", busy0, 0);
            if (i == 3) chk("t2_busy", busy0, 1);
            if (i == 5) chk("t2_out_pre", out0, 0);
            if (i == 6) chk("t2_rise", {out0, rise0}, 2'b11);
            if (i == 7) chk("t2_rise_off", {out0, rise0}, 2'b10);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        reset = 1'b1; m_reset();
        #1 chk("t5_out_async", out0, 0);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0);
            chk("t5_no_fall", fall0, 0);
        end
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        end
        chk("t4_sat", gl0, 255);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        chk("t4_busy_before_abort", busy0, 1);
        tick(1'b0, 1'b1);
        chk("t4_clr_vs_abort", gl0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic d;
            int len;
            d = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 199) == 0) do_reset();
                else tick(d, $urandom_range(0, 29) == 0);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
